tluh_atomic_host: RTL

Initiator-side TL-UH atomic engine. Accepts one atomic command at a time from a core- or DMA-side request port and issues it as a single-beat LogicalData (or, optionally, ArithmeticData) message on TileLink channel A. It waits for the matching AccessAckData on channel D and returns the pre-operation memory value to the requester. It is the issuing end of the atomic path whose responder side executes XOR/OR/AND/SWAP at the target.

---
 rtl/tluh_pkg.sv | 49 ++++
 rtl/tluh_atomic_host.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tluh_pkg.sv
// ============================================================================
//  Module   : tluh_pkg
//  Brief    : Shared TL-UH atomic definitions: A-channel params, opcodes,
//             host FSM states and the command legality check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tluh_pkg;

    typedef enum logic [2:0] {
        LOG_XOR  = 3'd0,
        LOG_OR   = 3'd1,
        LOG_AND  = 3'd2,
        LOG_SWAP = 3'd3
    } tluh_a_param_log;

    typedef enum logic [2:0] {
        ARITH_MIN  = 3'd0,
        ARITH_MAX  = 3'd1,
        ARITH_MINU = 3'd2,
        ARITH_MAXU = 3'd3,
        ARITH_ADD  = 3'd4
    } tluh_a_param_arith;

    localparam logic [2:0] c_LOGICAL_DATA    = 3'd3;
    localparam logic [2:0] c_ARITHMETIC_DATA = 3'd2;
    localparam logic [2:0] c_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } tluh_state_e;

    // Arithmetic commands are only legal when the build carries that support.
    function automatic logic tluh_cmd_legal(input logic       arith,
                                            input logic [2:0] param,
                                            input logic       arith_en);
        if (arith) begin
            return arith_en && (param <= ARITH_ADD);
        end
        return param <= LOG_SWAP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tluh_atomic_host.sv
// ============================================================================
//  Module   : tluh_atomic_host
//  Brief    : Initiator-side TL-UH atomic engine, one outstanding transaction.
//             Define TLUH_ARITH_EN to enable ArithmeticData requests.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tluh_atomic_host
    import tluh_pkg::*;
#(
    parameter int               SRC_W     = 8,
    parameter logic [SRC_W-1:0] SOURCE_ID = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  logic             req_arith_i,
    input  logic [2:0]       req_param_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,

    output logic             tl_a_valid_o,
    input  logic             tl_a_ready_i,
    output logic [2:0]       tl_a_opcode_o,
    output logic [2:0]       tl_a_param_o,
    output logic [1:0]       tl_a_size_o,
    output logic [SRC_W-1:0] tl_a_source_o,
    output logic [31:0]      tl_a_address_o,
    output logic [3:0]       tl_a_mask_o,
    output logic [31:0]      tl_a_data_o,

    input  logic             tl_d_valid_i,
    output logic             tl_d_ready_o,
    input  logic [2:0]       tl_d_opcode_i,
    input  logic [SRC_W-1:0] tl_d_source_i,
    input  logic [31:0]      tl_d_data_i,
    input  logic             tl_d_error_i
);

`ifdef TLUH_ARITH_EN
    localparam logic c_ARITH_EN = 1'b1;
    logic [2:0] w_opcode;
    assign w_opcode = req_arith_i ? c_ARITHMETIC_DATA : c_LOGICAL_DATA;
`else
    localparam logic c_ARITH_EN = 1'b0;
    logic [2:0] w_opcode;
    assign w_opcode = c_LOGICAL_DATA;
`endif

    tluh_state_e r_state;
    tluh_state_e w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_opcode;
    logic [2:0]  r_param;
    logic [31:0] r_rdata;
    logic        r_err;

    logic w_legal;
    logic w_send;
    logic w_d_err;
    logic w_unused_addr;

    assign w_legal       = tluh_cmd_legal(req_arith_i, req_param_i, c_ARITH_EN);
    assign w_send        = (r_state == ST_SEND);
    assign w_unused_addr = ^req_addr_i[1:0];
    assign w_d_err       = tl_d_error_i
                         | (tl_d_opcode_i != c_ACCESS_ACK_DATA)
                         | (tl_d_source_i != SOURCE_ID);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs decode from state alone, so no tl_* input reaches a tl_* output.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        tl_a_valid_o = 1'b0;
        tl_d_ready_o = 1'b0;
        rsp_valid_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o  = 1'b1;
                tl_d_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = w_legal ? ST_SEND : ST_RESP;
                end
            end
            ST_SEND: begin
                tl_a_valid_o = 1'b1;
                if (tl_a_ready_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tl_d_ready_o = 1'b1;
                if (tl_d_valid_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_opcode <= '0;
            r_param  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && req_valid_i) begin
                r_addr   <= {req_addr_i[31:2], 2'b00};
                r_wdata  <= req_wdata_i;
                r_opcode <= w_opcode;
                r_param  <= req_param_i;
                r_rdata  <= '0;
                r_err    <= ~w_legal;
            end
            if ((r_state == ST_WAIT) && tl_d_valid_i) begin
                r_rdata <= tl_d_data_i;
                r_err   <= w_d_err;
            end
        end
    end

    assign tl_a_opcode_o  = r_opcode;
    assign tl_a_param_o   = r_param;
    assign tl_a_address_o = r_addr;
    assign tl_a_data_o    = r_wdata;
    assign tl_a_size_o    = w_send ? 2'd2 : 2'd0;
    assign tl_a_mask_o    = w_send ? 4'hF : 4'h0;
    assign tl_a_source_o  = w_send ? SOURCE_ID : '0;

    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

`default_nettype wire
